// File: rtl/fetch_queue.sv
// fetch_queue: dual-slot instruction fetch queue between fetch and decode.
// Holds DEPTH {instr, pc} entries in a circular buffer. Up to two entries
// can be pushed and up to two popped per cycle. Slot 0 is always the older
// of a pair.
// Optional feature macro: FQ_BYPASS_EN. When it is defined, pushes into an
// empty queue appear on the outputs in the same cycle. When it is undefined,
// every output depends only on registered state.
// Word widths come from `IWIDTH and `DWIDTH. Both default to 32 bits.

`ifndef IWIDTH
`define IWIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       fq_i_clk,
  input  logic                       fq_i_rst,
  input  logic                       fq_i_flush,
  input  logic [1:0]                 fq_i_wr_vld,
  input  logic [`IWIDTH-1:0]         fq_i_instr0,
  input  logic [`IWIDTH-1:0]         fq_i_instr1,
  input  logic [`DWIDTH-1:0]         fq_i_pc0,
  input  logic [`DWIDTH-1:0]         fq_i_pc1,
  output logic                       fq_o_rdy,
  input  logic [1:0]                 fq_i_pop,
  output logic                       fq_o_ce0,
  output logic                       fq_o_ce1,
  output logic [`IWIDTH-1:0]         fq_o_instr0,
  output logic [`IWIDTH-1:0]         fq_o_instr1,
  output logic [`DWIDTH-1:0]         fq_o_pc0,
  output logic [`DWIDTH-1:0]         fq_o_pc1,
  output logic [$clog2(DEPTH):0]     fq_o_count,
  output logic                       fq_o_full,
  output logic                       fq_o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = `IWIDTH;
  localparam int DW = `DWIDTH;
  localparam logic [AW:0] RDY_MAX  = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO      = (AW+1)'(2);

  // Pointers carry one extra wrap bit. Their difference is the occupancy,
  // and it stays correct across wrap, including the full case.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;

  // Storage array. It has no reset, because the pointers alone define
  // which entries are live.
  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [DW-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] wr_idx0, wr_idx1;
  logic [AW-1:0] rd_idx0, rd_idx1;
  logic          rdy;
  logic          push_ok;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          we0, we1;

  // The visible head pair, before zero-masking.
  logic          vis_ce0, vis_ce1;
  logic [IW-1:0] vis_instr0, vis_instr1;
  logic [DW-1:0] vis_pc0, vis_pc1;

`ifdef FQ_BYPASS_EN
  // Bypass is active only when nothing is stored and the queue is not in
  // reset or a flush. Gating with reset keeps the outputs quiet while
  // reset is held.
  logic          byp;
  assign byp = (count == '0) & ~fq_i_flush & fq_i_rst;
`endif

  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdy     = (count <= RDY_MAX);
  assign push_ok = rdy & ~fq_i_flush;

  assign wr_idx0 = wr_ptr_q[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);
  assign rd_idx0 = rd_ptr_q[AW-1:0];
  assign rd_idx1 = rd_idx0 + AW'(1);

  // Count the accepted push slots. Slot 1 without slot 0 counts as no push.
  always_comb begin
    push_n = 2'd0;
    if (push_ok) begin
      case (fq_i_wr_vld)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  // Select the head pair presented to the decoder: stored entries normally,
  // or the incoming slots when bypassing into an empty queue.
  always_comb begin
    vis_ce0    = (count != '0);
    vis_ce1    = (count >= TWO);
    vis_instr0 = instr_mem_q[rd_idx0];
    vis_instr1 = instr_mem_q[rd_idx1];
    vis_pc0    = pc_mem_q[rd_idx0];
    vis_pc1    = pc_mem_q[rd_idx1];
`ifdef FQ_BYPASS_EN
    if (byp) begin
      vis_ce0    = (push_n != 2'd0);
      vis_ce1    = (push_n == 2'd2);
      vis_instr0 = fq_i_instr0;
      vis_instr1 = fq_i_instr1;
      vis_pc0    = fq_i_pc0;
      vis_pc1    = fq_i_pc1;
    end
`endif
  end

  // Count the accepted pops. Pop bits are honoured only against a valid
  // slot, and head+1 alone counts as no pop.
  always_comb begin
    pop_n = 2'd0;
    if (!fq_i_flush) begin
      case (fq_i_pop)
        2'b01:   pop_n = vis_ce0 ? 2'd1 : 2'd0;
        2'b11:   pop_n = vis_ce1 ? 2'd2 : (vis_ce0 ? 2'd1 : 2'd0);
        default: pop_n = 2'd0;
      endcase
    end
  end

  // Decide which accepted slots are written. A bypassed slot that the
  // decoder consumes in the same cycle is never written into storage.
  always_comb begin
    we0 = (push_n != 2'd0);
    we1 = (push_n == 2'd2);
`ifdef FQ_BYPASS_EN
    if (byp) begin
      we0 = (push_n != 2'd0) && (pop_n == 2'd0);
      we1 = (push_n == 2'd2) && (pop_n != 2'd2);
    end
`endif
  end

  // Next-state pointers. A flush empties the queue by aligning the read
  // pointer to the write pointer, so any same-cycle push or pop is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fq_i_flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_n);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop_n);
    end
  end

  // Pointer registers. Reset discards all contents immediately.
  always_ff @(posedge fq_i_clk or negedge fq_i_rst) begin
    if (!fq_i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage writes. Slot 0 goes to the write pointer and slot 1 to the next
  // location, modulo DEPTH.
  always_ff @(posedge fq_i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we0 && (wr_idx0 == AW'(i))) begin
        instr_mem_q[i] <= fq_i_instr0;
        pc_mem_q[i]    <= fq_i_pc0;
      end else if (we1 && (wr_idx1 == AW'(i))) begin
        instr_mem_q[i] <= fq_i_instr1;
        pc_mem_q[i]    <= fq_i_pc1;
      end
    end
  end

  // Decoder-facing outputs. Data is zero whenever its slot is not valid.
  assign fq_o_ce0    = vis_ce0;
  assign fq_o_ce1    = vis_ce1;
  assign fq_o_instr0 = vis_ce0 ? vis_instr0 : '0;
  assign fq_o_instr1 = vis_ce1 ? vis_instr1 : '0;
  assign fq_o_pc0    = vis_ce0 ? vis_pc0 : '0;
  assign fq_o_pc1    = vis_ce1 ? vis_pc1 : '0;

  // Occupancy status.
  assign fq_o_rdy    = rdy;
  assign fq_o_count  = count;
  assign fq_o_full   = (count == FULL_CNT);
  assign fq_o_empty  = (count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue.
// The stimulus process decides from queue occupancy which pushes are
// accepted and records the expected entries. A negedge monitor compares the
// presented head pair and the status flags against the reference queue, then
// retires the entries that the decoder accepts.
// Define FQ_BYPASS_EN to also cover the same-cycle bypass behaviour.

`ifndef IWIDTH
`define IWIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int IW    = `IWIDTH;
  localparam int DW    = `DWIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [IW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    wr_vld = 2'b00;
  logic [IW-1:0] instr0 = '0, instr1 = '0;
  logic [DW-1:0] pc0 = '0, pc1 = '0;
  logic [1:0]    pop = 2'b00;
  logic          rdy, ce0, ce1, full, empty;
  logic [IW-1:0] o_instr0, o_instr1;
  logic [DW-1:0] o_pc0, o_pc1;
  logic [CW-1:0] count;

  ent_t exp_q[$];
  ent_t pend_q[$];
  bit   pend_flush = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   txn = 0;
  logic [DW-1:0] pc_ctr = '0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .fq_i_clk(clk), .fq_i_rst(rst_n), .fq_i_flush(flush),
    .fq_i_wr_vld(wr_vld), .fq_i_instr0(instr0), .fq_i_instr1(instr1),
    .fq_i_pc0(pc0), .fq_i_pc1(pc1), .fq_o_rdy(rdy), .fq_i_pop(pop),
    .fq_o_ce0(ce0), .fq_o_ce1(ce1), .fq_o_instr0(o_instr0),
    .fq_o_instr1(o_instr1), .fq_o_pc0(o_pc0), .fq_o_pc1(o_pc1),
    .fq_o_count(count), .fq_o_full(full), .fq_o_empty(empty)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (txn %0d)", nm, act, req, txn);
    end
  endfunction

  // Monitor: compare what the DUT presents with the reference queue, then
  // retire the entries that the decoder accepts.
  ent_t view[$];
  bit   from_pend;
  int   nv, np;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ce0", 64'(ce0), 64'd0);
      chk("rst_ce1", 64'(ce1), 64'd0);
      chk("rst_pc0", 64'(o_pc0), 64'd0);
      chk("rst_instr1", 64'(o_instr1), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_rdy", 64'(rdy), 64'd1);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
    end else begin
      view = exp_q;
      from_pend = 1'b0;
`ifdef FQ_BYPASS_EN
      if (exp_q.size() == 0 && !flush) begin
        view = pend_q;
        from_pend = 1'b1;
      end
`endif
      nv = view.size();
      chk("ce0", 64'(ce0), 64'(nv >= 1));
      chk("ce1", 64'(ce1), 64'(nv >= 2));
      chk("instr0", 64'(o_instr0), (nv >= 1) ? 64'(view[0][IW+DW-1:DW]) : 64'd0);
      chk("pc0", 64'(o_pc0), (nv >= 1) ? 64'(view[0][DW-1:0]) : 64'd0);
      chk("instr1", 64'(o_instr1), (nv >= 2) ? 64'(view[1][IW+DW-1:DW]) : 64'd0);
      chk("pc1", 64'(o_pc1), (nv >= 2) ? 64'(view[1][DW-1:0]) : 64'd0);
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
      chk("empty", 64'(empty), 64'(exp_q.size() == 0));
      chk("rdy", 64'(rdy), 64'(exp_q.size() <= DEPTH - 2));
      np = (pop == 2'b01) ? 1 : ((pop == 2'b11) ? 2 : 0);
      if (np > nv) np = nv;
      if (flush) np = 0;
      for (int k = 0; k < np; k++) begin
        if (from_pend) void'(pend_q.pop_front());
        else void'(exp_q.pop_front());
      end
    end
  end

  // Issue one cycle of stimulus. First, commit the previous cycle's
  // accepted pushes into the reference queue (or drop everything if that
  // cycle flushed). Then drive the new inputs.
  task automatic drive(input logic [1:0] wv, input logic [1:0] pp, input logic fl,
                       input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                       input logic [IW-1:0] i0, input logic [IW-1:0] i1);
    int n;
    @(posedge clk);
    #1;
    if (pend_flush) exp_q.delete();
    else foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
    pend_q.delete();
    wr_vld = wv; pop = pp; flush = fl;
    pc0 = p0; pc1 = p1; instr0 = i0; instr1 = i1;
    n = 0;
    if (!fl && exp_q.size() <= DEPTH - 2)
      n = (wv == 2'b01) ? 1 : ((wv == 2'b11) ? 2 : 0);
    if (n >= 1) pend_q.push_back({i0, p0});
    if (n == 2) pend_q.push_back({i1, p1});
    pend_flush = fl;
    txn++;
    $display("txn %0d wr_vld=%b pop=%b flush=%b pc0=%h pc1=%h stored=%0d accepted=%0d",
             txn, wv, pp, fl, p0, p1, exp_q.size(), n);
  endtask

  // Drive with sequential PCs and random instruction words.
  task automatic step(input logic [1:0] wv, input logic [1:0] pp, input logic fl);
    logic [DW-1:0] a;
    a = pc_ctr;
    pc_ctr = pc_ctr + DW'(8);
    drive(wv, pp, fl, a, a + DW'(4), IW'($urandom), IW'($urandom));
  endtask

  initial begin
    // Reset is held for a few cycles. The monitor checks the reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-slot push: both slots visible on the next cycle.
    drive(2'b11, 2'b00, 1'b0, DW'(32'h0), DW'(32'h4), IW'(32'h20080005), IW'(32'h20090003));
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    // Fill to DEPTH, then check that a further push is ignored.
    repeat (DEPTH / 2) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    // Reach count 7, then push 2 with pop 2: the push is blocked, count 5.
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b11, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    // Steady push 1 / pop 1 across pointer wrap.
    step(2'b01, 2'b00, 1'b0);
    repeat (20) step(2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    // Flush at count 5 overrides a same-cycle push and pop.
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b01, 1'b1);
    step(2'b00, 2'b00, 1'b0);

`ifdef FQ_BYPASS_EN
    // Bypass into an empty queue, consumed in the same cycle.
    drive(2'b01, 2'b01, 1'b0, DW'(32'h40), DW'(32'h44), IW'($urandom), IW'($urandom));
    step(2'b00, 2'b00, 1'b0);
`endif

    // Reset mid-operation discards contents immediately.
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_vld = 2'b00; pop = 2'b00; flush = 1'b0;
    exp_q.delete(); pend_q.delete(); pend_flush = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_ce0", 64'(ce0), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
    end

    // Drain the last pending commit through the monitor.
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of queue entries (power of two, minimum 4).
REQ-002 SHALL provide port fq_i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port fq_i_rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL provide port fq_i_flush, input, 1, discard all queued instructions (branch/jump redirect).
REQ-005 SHALL provide port fq_i_wr_vld, input, 2, push valid; bit0 = slot 0, bit1 = slot 1.
REQ-006 SHALL provide ports fq_i_instr0 and fq_i_instr1, input, `IWIDTH each, fetched instruction words.
REQ-007 SHALL provide ports fq_i_pc0 and fq_i_pc1, input, `DWIDTH each, PCs of the pushed instructions.
REQ-008 SHALL provide port fq_o_rdy, output, 1, high when at least two entries are free.
REQ-009 SHALL provide port fq_i_pop, input, 2, decoder accept; bit0 = head, bit1 = head+1.
REQ-010 SHALL provide ports fq_o_ce0 and fq_o_ce1, output, 1 each, slot valid; these drive decoder d_i_ce.
REQ-011 SHALL provide ports fq_o_instr0/1 (`IWIDTH) and fq_o_pc0/1 (`DWIDTH), outputs, head and head+1 contents.
REQ-012 SHALL provide ports fq_o_count (log2(DEPTH)+1 bits), fq_o_full and fq_o_empty, outputs, occupancy status.

Function
REQ-013 SHALL be a circular buffer of DEPTH {instr, pc} entries, with read/write pointers carrying one extra wrap bit.
REQ-014 SHALL accept a push only when fq_o_rdy=1; a push with fq_o_rdy=0 is ignored, and the state is unchanged by it.
REQ-015 SHALL treat fq_i_wr_vld=2'b10 as 2'b00 and fq_i_pop=2'b10 as 2'b00; slot 0 is always older than slot 1.
REQ-016 SHALL write slot 0 at the write pointer and slot 1 at write pointer+1, modulo DEPTH.
REQ-017 SHALL drive fq_o_ce0 = (count>=1), fq_o_ce1 = (count>=2); instr/pc outputs are zero when the matching ce is 0.
REQ-018 SHALL ignore pop bits whose matching ce is 0.
REQ-019 SHALL update count_next = count + pushes - pops, with pops evaluated on pre-edge contents; simultaneous push and pop are legal.
REQ-020 SHALL make a pushed entry visible on fq_o_* one cycle after the push edge (1-cycle latency).
REQ-021 SHALL give fq_i_flush priority: next cycle count=0 and pointers equal; same-cycle push and pop are discarded.
REQ-022 SHALL derive fq_o_rdy = (count <= DEPTH-2), fq_o_full = (count == DEPTH), fq_o_empty = (count == 0).
REQ-023 SHALL wrap pointers modulo DEPTH with the wrap bit toggling; full/empty detection is correct across wrap.

Reset
REQ-024 SHALL, while fq_i_rst=0, clear pointers and count and hold fq_o_ce0/1=0, fq_o_instr0/1=0, fq_o_pc0/1=0, fq_o_rdy=1, fq_o_empty=1 and fq_o_full=0.
REQ-025 SHALL, on reset assertion mid-operation, discard all contents immediately; storage array contents need not be cleared.

Configuration
REQ-026 SHALL support macro FQ_BYPASS_EN; when defined and the queue is empty with no flush, pushed slots appear on fq_o_* combinationally in the same cycle.
REQ-027 SHALL, with FQ_BYPASS_EN defined, not store a bypassed instruction that is popped in the same cycle.
REQ-028 SHALL, without FQ_BYPASS_EN, hold all outputs purely a function of registered state (latency per REQ-020).

Verification
REQ-029 SHALL cover: reset, push 2 (pc 0x0,0x4, instr 0x20080005/0x20090003) -> next cycle ce0=ce1=1, pc0=0x0, pc1=0x4, count=2.
REQ-030 SHALL cover: push 2 per cycle for 4 cycles with no pop (DEPTH=8) -> count=8, full=1, rdy=0; a fifth push is ignored and count stays 8.
REQ-031 SHALL cover: count=7, push 2 with pop 2 in the same cycle -> rdy=0 blocks the push, and count becomes 5 next cycle.
REQ-032 SHALL cover: 20 cycles of push 1/pop 1 -> PCs emerge in order across pointer wrap, and count stays at 1.
REQ-033 SHALL cover: count=5, flush asserted with push 2 and pop 1 -> next cycle count=0, empty=1, ce0=0.
REQ-034 SHALL cover, with FQ_BYPASS_EN defined: empty queue, push 1 (pc 0x40) with pop 1 -> same-cycle ce0=1, pc0=0x40, and count stays 0.
